// File: rtl/bq_meas_scanner.sv
// bq_meas_scanner: sequences an external ADC over cells/current/TS and publishes coherent frames.
// Define BQ_SCAN_OVERSAMPLE_EN for 4x oversampling per channel.
module bq_meas_scanner #(
  parameter int NUM_CELLS   = 16,
  parameter int ADC_W       = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       scan_start,
  input  logic                       scan_cont,
  input  logic                       clr_err,
  output logic [4:0]                 mux_sel,
  output logic                       adc_req,
  input  logic                       adc_ack,
  input  logic [ADC_W-1:0]           adc_data,
  output logic [NUM_CELLS*ADC_W-1:0] cell_v,
  output logic [ADC_W-1:0]           current,
  output logic [ADC_W-1:0]           ts1,
  output logic [ADC_W-1:0]           ts2,
  output logic [ADC_W-1:0]           ts3,
  output logic [ADC_W-1:0]           vmin,
  output logic [ADC_W-1:0]           vmax,
  output logic [3:0]                 vmin_idx,
  output logic [3:0]                 vmax_idx,
  output logic                       frame_valid,
  output logic                       busy,
  output logic                       adc_timeout
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, STORE, PUBLISH} state_t;
  state_t state;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [ADC_W-1:0] sh [20];
  logic [ADC_W-1:0] rmin, rmax, res, val;
  logic [3:0] rmin_i, rmax_i;
  logic ok, is_cell, timeout_hit;
  assign is_cell = mux_sel < 5'd16;
  assign timeout_hit = state == CONVERT && adc_req && !adc_ack && tcnt == TW'(TIMEOUT_CYC - 1);
  // a timed-out channel re-stores its previous shadow so min/max still sees the old value
  assign val = ok ? res : sh[mux_sel];
`ifdef BQ_SCAN_OVERSAMPLE_EN
  logic [ADC_W+1:0] acc, sum;
  logic [1:0] ncv;
  assign sum = acc + (is_cell ? {2'b00, adc_data} : {{2{adc_data[ADC_W-1]}}, adc_data});
  assign res = acc[ADC_W+1:2];
`else
  logic [ADC_W-1:0] acc;
  assign res = acc;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      scnt <= '0;
      tcnt <= '0;
      for (int c = 0; c < 20; c++) sh[c] <= '0;
      rmin <= '0;
      rmax <= '0;
      rmin_i <= '0;
      rmax_i <= '0;
      ok <= 1'b0;
      acc <= '0;
`ifdef BQ_SCAN_OVERSAMPLE_EN
      ncv <= '0;
`endif
      mux_sel <= '0;
      adc_req <= 1'b0;
      cell_v <= '0;
      current <= '0;
      ts1 <= '0;
      ts2 <= '0;
      ts3 <= '0;
      vmin <= '0;
      vmax <= '0;
      vmin_idx <= '0;
      vmax_idx <= '0;
      frame_valid <= 1'b0;
      busy <= 1'b0;
      adc_timeout <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      adc_timeout <= timeout_hit | (adc_timeout & ~clr_err);
      case (state)
        IDLE: if (scan_start || scan_cont) begin
          state <= SETTLE;
          busy <= 1'b1;
          mux_sel <= '0;
          scnt <= '0;
        end
        SETTLE: begin
          busy <= 1'b1;
          scnt <= scnt + 1'b1;
          if (scnt == SW'(SETTLE_CYC - 1)) begin
            state <= CONVERT;
            adc_req <= 1'b1;
            tcnt <= '0;
            ok <= 1'b1;
            acc <= '0;
`ifdef BQ_SCAN_OVERSAMPLE_EN
            ncv <= '0;
`endif
          end
        end
        CONVERT: if (!adc_req) begin
          adc_req <= 1'b1;
          tcnt <= '0;
        end else if (adc_ack) begin
          adc_req <= 1'b0;
`ifdef BQ_SCAN_OVERSAMPLE_EN
          acc <= sum;
          ncv <= ncv + 2'd1;
          if (ncv == 2'd3) state <= STORE;
`else
          acc <= adc_data;
          state <= STORE;
`endif
        end else if (timeout_hit) begin
          adc_req <= 1'b0;
          ok <= 1'b0;
          state <= STORE;
        end else tcnt <= tcnt + 1'b1;
        STORE: begin
          sh[mux_sel] <= val;
          if (is_cell && (mux_sel == 5'd0 || val < rmin)) begin
            rmin <= val;
            rmin_i <= mux_sel[3:0];
          end
          if (is_cell && (mux_sel == 5'd0 || val > rmax)) begin
            rmax <= val;
            rmax_i <= mux_sel[3:0];
          end
          scnt <= '0;
          state <= mux_sel == 5'd19 ? PUBLISH : SETTLE;
          mux_sel <= mux_sel == 5'd19 ? 5'd19 : mux_sel == 5'(NUM_CELLS - 1) ? 5'd16 : mux_sel + 5'd1;
        end
        PUBLISH: begin
          for (int c = 0; c < NUM_CELLS; c++) cell_v[c*ADC_W +: ADC_W] <= sh[c];
          current <= sh[16];
          ts1 <= sh[17];
          ts2 <= sh[18];
          ts3 <= sh[19];
          vmin <= rmin;
          vmax <= rmax;
          vmin_idx <= rmin_i;
          vmax_idx <= rmax_i;
          frame_valid <= 1'b1;
          busy <= 1'b0;
          mux_sel <= '0;
          scnt <= '0;
          state <= scan_cont ? SETTLE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
